// File: rtl/adder_pipe.sv
// Purpose : pipelined add/subtract, one CW-bit carry chunk per stage, signed/unsigned per transaction.
// Latency : STAGES cycles from acceptance to out_valid; throughput 1 per cycle.
// Backpr. : out_valid && !in_accept freezes the whole pipeline; out_ready = !stall (bubbles kept).
//
// Ports:
//   in_clk, in_rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / out_ready       operand handshake (in_x, in_y, in_sub, in_signed)
//   out_valid / in_accept      result handshake (out_result, out_carry, out_overflow, out_zero)
//   out_ovf_sticky             sticky OR of out_overflow over completed transfers
//   in_clr_sticky              clears the sticky flag (a same-cycle set wins)
//
// Optional build macro ADDER_PIPE_SAT_EN: saturate out_result on overflow in the
// last stage. Without it the result wraps modulo 2^WIDTH.
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_sub,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             in_accept,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_ovf_sticky,
  input  logic             in_clr_sticky
);

  localparam int CW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("adder_pipe: WIDTH (%0d) must be divisible by STAGES (%0d), 1 <= STAGES <= WIDTH",
           WIDTH, STAGES);
  end

`ifdef ADDER_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Per-stage registers. x/y' travel whole so the upper, not-yet-added chunks
  // are available downstream; r holds the low chunks already summed.
  logic             vld_q [STAGES];
  logic             vld_d [STAGES];
  logic [WIDTH-1:0] x_q   [STAGES];
  logic [WIDTH-1:0] x_d   [STAGES];
  logic [WIDTH-1:0] y_q   [STAGES];
  logic [WIDTH-1:0] y_d   [STAGES];
  logic [WIDTH-1:0] r_q   [STAGES];
  logic [WIDTH-1:0] r_d   [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic             sub_q [STAGES];
  logic             sub_d [STAGES];
  logic             sgn_q [STAGES];
  logic             sgn_d [STAGES];
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;

  // Stage inputs: stage 0 is fed from the ports, stage k from register k-1.
  logic             si_vld [STAGES];
  logic [WIDTH-1:0] si_x   [STAGES];
  logic [WIDTH-1:0] si_y   [STAGES];
  logic [WIDTH-1:0] si_r   [STAGES];
  logic             si_c   [STAGES];
  logic             si_sub [STAGES];
  logic             si_sgn [STAGES];

  logic stall;

  assign stall     = vld_q[L] && !in_accept;
  assign out_ready = !stall;

  always_comb begin
    si_vld[0] = in_valid;
    si_x[0]   = in_x;
    si_y[0]   = in_sub ? ~in_y : in_y;   // subtract as x + ~y + 1
    si_r[0]   = '0;
    si_c[0]   = in_sub;
    si_sub[0] = in_sub;
    si_sgn[0] = in_signed;
    for (int k = 1; k < STAGES; k++) begin
      si_vld[k] = vld_q[k-1];
      si_x[k]   = x_q[k-1];
      si_y[k]   = y_q[k-1];
      si_r[k]   = r_q[k-1];
      si_c[k]   = c_q[k-1];
      si_sub[k] = sub_q[k-1];
      si_sgn[k] = sgn_q[k-1];
    end
  end

  always_comb begin : stage_math
    logic [CW:0] sum;
    sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      sum = {1'b0, si_x[k][k*CW +: CW]} + {1'b0, si_y[k][k*CW +: CW]}
          + {{CW{1'b0}}, si_c[k]};
      vld_d[k]            = si_vld[k];
      x_d[k]              = si_x[k];
      y_d[k]              = si_y[k];
      r_d[k]              = si_r[k];
      r_d[k][k*CW +: CW]  = sum[CW-1:0];
      c_d[k]              = sum[CW];
      sub_d[k]            = si_sub[k];
      sgn_d[k]            = si_sgn[k];
    end

    // Flags come from the raw (unsaturated) final sum.
    if (si_sgn[L]) begin
      ovf_d = (si_x[L][WIDTH-1] == si_y[L][WIDTH-1]) &&
              (r_d[L][WIDTH-1] != si_x[L][WIDTH-1]);
    end else begin
      ovf_d = si_sub[L] ? !c_d[L] : c_d[L];
    end

`ifdef ADDER_PIPE_SAT_EN
    if (ovf_d) begin
      if (si_sgn[L]) begin
        r_d[L] = si_x[L][WIDTH-1] ? SMIN : SMAX;
      end else if (si_sub[L]) begin
        r_d[L] = '0;
      end else begin
        r_d[L] = '1;
      end
    end
`endif

    // Whole pipeline freezes on a stall.
    if (stall) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_d[k] = vld_q[k];
        x_d[k]   = x_q[k];
        y_d[k]   = y_q[k];
        r_d[k]   = r_q[k];
        c_d[k]   = c_q[k];
        sub_d[k] = sub_q[k];
        sgn_d[k] = sgn_q[k];
      end
      ovf_d = ovf_q;
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    if (in_clr_sticky) begin
      sticky_d = 1'b0;
    end
    if (vld_q[L] && in_accept && ovf_q) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        x_q[k]   <= '0;
        y_q[k]   <= '0;
        r_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        sub_q[k] <= 1'b0;
        sgn_q[k] <= 1'b0;
      end
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        x_q[k]   <= x_d[k];
        y_q[k]   <= y_d[k];
        r_q[k]   <= r_d[k];
        c_q[k]   <= c_d[k];
        sub_q[k] <= sub_d[k];
        sgn_q[k] <= sgn_d[k];
      end
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid      = vld_q[L];
  assign out_result     = r_q[L];
  assign out_carry      = c_q[L];
  assign out_overflow   = ovf_q;
  assign out_zero       = (r_q[L] == '0);
  assign out_ovf_sticky = sticky_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Purpose : scoreboard bench for adder_pipe (WIDTH=8, STAGES=2) with an arithmetic reference model.
// Latency : expects results STAGES cycles after acceptance whenever the sink never stalls.
// Backpr. : sink drives in_accept held-high, held-low or random; outputs must hold while stalled.
module tb_adder_pipe;

  localparam int W = 8;
  localparam int S = 2;

  logic         in_clk, in_rst_n, in_valid, out_ready;
  logic [W-1:0] in_x, in_y;
  logic         in_sub, in_signed, out_valid, in_accept;
  logic [W-1:0] out_result;
  logic         out_carry, out_overflow, out_zero, out_ovf_sticky, in_clr_sticky;

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_valid(in_valid), .out_ready(out_ready),
    .in_x(in_x), .in_y(in_y), .in_sub(in_sub), .in_signed(in_signed),
    .out_valid(out_valid), .in_accept(in_accept), .out_result(out_result),
    .out_carry(out_carry), .out_overflow(out_overflow), .out_zero(out_zero),
    .out_ovf_sticky(out_ovf_sticky), .in_clr_sticky(in_clr_sticky)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0, n_bad = 0, cyc = 0, n_push = 0, n_pop = 0;
  int   acc_mode = 0;          // 0: accept held 1, 1: random, 2: accept held 0
  logic clr_req = 1'b0;
  logic lat_chk = 1'b0;
  logic m_sticky = 1'b0;
  logic stall_prev = 1'b0;
  logic [W-1:0] prev_res;
  logic prev_c, prev_v;

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;
  always @(posedge in_clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sub, input logic sgn);
    exp_t e;
    int ux, uy, sx, sy, full, sres;
    logic ovf;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sub) begin
      full = ux - uy;
      e.c  = (ux >= uy);
      sres = sx - sy;
    end else begin
      full = ux + uy;
      e.c  = (full >= (1 << W));
      sres = sx + sy;
    end
    e.res = full[W-1:0];
    if (sgn) ovf = (sres > (1 << (W-1)) - 1) || (sres < -(1 << (W-1)));
    else     ovf = sub ? !e.c : e.c;
    e.v = ovf;
`ifdef ADDER_PIPE_SAT_EN
    if (ovf) begin
      if (sgn)      e.res = (sx < 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else if (sub) e.res = '0;
      else          e.res = '1;
    end
`endif
    e.z   = (e.res == '0);
    e.cyc = 0;
    return e;
  endfunction

  // Sink: in_accept and in_clr_sticky change only at posedge+1.
  initial begin
    in_accept     = 1'b1;
    in_clr_sticky = 1'b0;
    forever begin
      @(posedge in_clk);
      #1;
      case (acc_mode)
        0:       in_accept = 1'b1;
        1:       in_accept = ($urandom % 4) != 0;
        default: in_accept = 1'b0;
      endcase
      in_clr_sticky = (acc_mode == 1) ? (($urandom % 10) == 0) : clr_req;
    end
  end

  // Monitor: pops the scoreboard on every completed transfer.
  always @(negedge in_clk) begin : mon
    exp_t e;
    logic set;
    if (!in_rst_n) begin
      m_sticky   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      set = 1'b0;
      chk("out_ready", out_ready, !(out_valid && !in_accept));
      chk("sticky", out_ovf_sticky, m_sticky);
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_result", out_result, prev_res);
        chk("hold_carry", out_carry, prev_c);
        chk("hold_ovf", out_overflow, prev_v);
      end
      if (out_valid && in_accept) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_output: result 0x%0h with empty scoreboard (t=%0t)",
                   out_result, $time);
        end else begin
          e = q.pop_front();
          n_pop++;
          chk("result", out_result, e.res);
          chk("carry", out_carry, e.c);
          chk("overflow", out_overflow, e.v);
          chk("zero", out_zero, e.z);
          if (lat_chk) chk("latency", cyc - e.cyc, S);
          set = e.v;
        end
      end
      if (set) m_sticky = 1'b1;
      else if (in_clr_sticky) m_sticky = 1'b0;
      stall_prev = out_valid && !in_accept;
      prev_res   = out_result;
      prev_c     = out_carry;
      prev_v     = out_overflow;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic sub, input logic sgn);
    exp_t e;
    bit done;
    done = 0;
    in_valid = 1'b1; in_x = x; in_y = y; in_sub = sub; in_signed = sgn;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge in_clk);
      if (out_ready) begin
        e = model(x, y, sub, sgn);
        e.cyc = cyc;
        q.push_back(e);
        n_push++;
        done = 1;
      end
      @(posedge in_clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_bad++;
      $display("FAIL send_timeout: operand not accepted within 200 cycles (t=%0t)", $time);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge in_clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) begin
      @(posedge in_clk);
      #1;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic set_mode(input int m);
    @(posedge in_clk);
    acc_mode = m;
    #1;
  endtask

  task automatic clr_pulse();
    @(posedge in_clk);
    clr_req = 1'b1;
    @(posedge in_clk);
    clr_req = 1'b0;
    #1;
  endtask

  initial begin
    in_rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_sub = 1'b0; in_signed = 1'b0;
    repeat (3) @(posedge in_clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_carry", out_carry, 0);
    chk("rst_ovf", out_overflow, 0);
    chk("rst_zero", out_zero, 1);
    chk("rst_sticky", out_ovf_sticky, 0);
    chk("rst_ready", out_ready, 1);
    in_rst_n = 1'b1;
    idle(1);

    // Directed vectors, sink never stalls, exact latency checked.
    lat_chk = 1'b1;
    send(8'hF0, 8'h20, 1'b0, 1'b0);
    send(8'h7F, 8'h01, 1'b0, 1'b1);
    send(8'h80, 8'h01, 1'b1, 1'b1);
    send(8'h05, 8'h05, 1'b1, 1'b0);
    send(8'h00, 8'h01, 1'b1, 1'b0);
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    send(8'h80, 8'h80, 1'b0, 1'b1);
    send(8'h12, 8'h34, 1'b0, 1'b1);
    drain();

    // Sticky: clear, set, set-vs-clear collision, clear alone.
    clr_pulse();
    @(negedge in_clk);
    chk("sticky_clr0", out_ovf_sticky, 0);
    @(posedge in_clk); #1;
    send(8'hF0, 8'h20, 1'b0, 1'b0);
    drain();
    @(negedge in_clk);
    chk("sticky_set", out_ovf_sticky, 1);
    @(posedge in_clk); #1;
    send(8'hFF, 8'h02, 1'b0, 1'b0);
    clr_pulse();                       // clear lands in the transfer cycle
    @(negedge in_clk);
    chk("sticky_set_wins", out_ovf_sticky, 1);
    @(posedge in_clk); #1;
    clr_pulse();
    @(negedge in_clk);
    chk("sticky_clr_alone", out_ovf_sticky, 0);
    @(posedge in_clk); #1;

    // Stall: three back-to-back ops, sink held off after first result.
    lat_chk = 1'b0;
    set_mode(2);
    fork
      begin
        send(8'h11, 8'h22, 1'b0, 1'b0);
        send(8'h33, 8'h44, 1'b1, 1'b0);
        send(8'h7F, 8'h7F, 1'b0, 1'b1);
      end
      begin
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge in_clk);
        chk("stall_seen_valid", out_valid, 1);
        chk("stall_ready_low", out_ready, 0);
        repeat (3) @(posedge in_clk);
        acc_mode = 0;
      end
    join
    drain();

    // Random traffic with random backpressure and clears.
    set_mode(1);
    for (int i = 0; i < 300; i++) begin
      if (($urandom % 4) == 0) idle($urandom_range(1, 3));
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end
    set_mode(0);
    drain();
    chk("delivered_once", n_pop, n_push);

    // Reset with two ops in flight.
    send(8'hF0, 8'h20, 1'b0, 1'b0);
    drain();
    send(8'hF0, 8'h20, 1'b0, 1'b0);
    send(8'h7F, 8'h01, 1'b0, 1'b1);
    #1;
    in_rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_sticky", out_ovf_sticky, 0);
    chk("arst_result", out_result, 0);
    q.delete();
    @(posedge in_clk);
    #1;
    in_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge in_clk);
      chk("post_rst_valid", out_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
